// File: rtl/skin_centroid_pkg.sv
// skin_pkg: shared widths, FSM state type and small helpers for the
// skin_centroid block and its sequential dividers.
package skin_pkg;

  localparam int unsigned X_W   = 11;
  localparam int unsigned Y_W   = 10;
  localparam int unsigned CNT_W = 20;
  localparam int unsigned SUM_W = 32;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DIV   = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per cycle.
// start loads operands (they may change afterwards); W iterations follow,
// then done pulses for one cycle with the quotient valid until next start.
module seq_divider
  import skin_pkg::*;
#(
  parameter int unsigned W = SUM_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  rem_q;
  logic [W-1:0]  div_q;
  logic [CW-1:0] cnt_q;
  logic [W:0]    shifted;
  logic [W:0]    trial;

  // Next partial remainder and trial subtraction for the current step.
  always_comb begin
    shifted = {rem_q, quotient[W-1]};
    trial   = shifted - {1'b0, div_q};
  end

  // Operand load on start, then one restoring step per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      quotient <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q    <= '0;
        div_q    <= divisor;
        quotient <= dividend;
        cnt_q    <= CW'(W);
        busy     <= 1'b1;
      end else if (busy) begin
        if (!trial[W]) begin
          rem_q    <= trial[W-1:0];
          quotient <= {quotient[W-2:0], 1'b1};
        end else begin
          rem_q    <= shifted[W-1:0];
          quotient <= {quotient[W-2:0], 1'b0};
        end
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/skin_centroid.sv
// skin_centroid: accumulates the coordinates of skin pixels over a frame
// and reports their truncated mean at each v_sync rising edge.
// Optional overlay: define SKIN_CENTROID_MARK_EN to draw the last valid
// centroid row/column (0x80) into pix_out.
module skin_centroid
  import skin_pkg::*;
#(
  parameter int unsigned H_RES     = 1280,
  parameter int unsigned V_RES     = 720,
  parameter int unsigned MIN_COUNT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           de,
  input  logic           h_sync,
  input  logic           v_sync,
  input  logic [7:0]     mask,
  output logic           de_out,
  output logic           h_sync_out,
  output logic           v_sync_out,
  output logic [7:0]     pix_out,
  output logic [X_W-1:0] centroid_x,
  output logic [Y_W-1:0] centroid_y,
  output logic           detected,
  output logic           result_valid,
  output logic           overrun
);

  state_t state_q, state_d;

  logic [X_W-1:0]   x_cnt;
  logic [Y_W-1:0]   y_cnt;
  logic [SUM_W-1:0] sum_x;
  logic [SUM_W-1:0] sum_y;
  logic [CNT_W-1:0] cnt;

  logic de_fall;
  logic vs_rise;
  logic skin;
  logic enough;
  logic accept;
  logic start_div;

  logic             busy_x, busy_y;
  logic             done_x, done_y;
  logic [SUM_W-1:0] quo_x, quo_y;
  logic             unused_ok;

  // Edge detection reuses the 1-cycle delayed timing outputs as history.
  always_comb begin
    de_fall   = de_out & ~de;
    vs_rise   = v_sync & ~v_sync_out;
    skin      = de & ~v_sync & (mask != '0);
    enough    = (cnt >= CNT_W'(MIN_COUNT));
    accept    = (state_q == ST_ACCUM) && vs_rise;
    start_div = accept && enough;
  end

  // Timing pass-through and pixel output, all delayed by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_out     <= 1'b0;
      h_sync_out <= 1'b0;
      v_sync_out <= 1'b0;
      pix_out    <= '0;
    end else begin
      de_out     <= de;
      h_sync_out <= h_sync;
      v_sync_out <= v_sync;
`ifdef SKIN_CENTROID_MARK_EN
      if (de && detected && (x_cnt == centroid_x || y_cnt == centroid_y))
        pix_out <= 8'h80;
      else
        pix_out <= mask;
`else
      pix_out    <= mask;
`endif
    end
  end

  // Pixel position: x walks the active line, y counts completed lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      if (de_fall)
        x_cnt <= '0;
      else if (de && x_cnt != X_W'(H_RES - 1))
        x_cnt <= x_cnt + 1'b1;

      if (vs_rise)
        y_cnt <= '0;
      else if (de_fall && y_cnt != Y_W'(V_RES - 1))
        y_cnt <= y_cnt + 1'b1;
    end
  end

  // Frame accumulators; every v_sync rise restarts them, accepted or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_x <= '0;
      sum_y <= '0;
      cnt   <= '0;
    end else if (vs_rise) begin
      sum_x <= '0;
      sum_y <= '0;
      cnt   <= '0;
    end else if (skin) begin
      sum_x <= sum_x + SUM_W'(x_cnt);
      sum_y <= sum_y + SUM_W'(y_cnt);
      cnt   <= sat_inc(cnt);
    end
  end

  // The dividers latch the pre-clear sums on start, acting as the snapshot.
  seq_divider #(.W(SUM_W)) u_div_x (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_div),
    .dividend (sum_x),
    .divisor  (SUM_W'(cnt)),
    .busy     (busy_x),
    .done     (done_x),
    .quotient (quo_x)
  );

  seq_divider #(.W(SUM_W)) u_div_y (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_div),
    .dividend (sum_y),
    .divisor  (SUM_W'(cnt)),
    .busy     (busy_y),
    .done     (done_y),
    .quotient (quo_y)
  );

  // Mean coordinates never exceed the position widths; upper bits are zero.
  assign unused_ok = ^{quo_x[SUM_W-1:X_W], quo_y[SUM_W-1:Y_W], busy_x, busy_y};

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= ST_ACCUM;
    else
      state_q <= state_d;
  end

  // FSM next state and the DONE strobe.
  always_comb begin
    state_d      = state_q;
    result_valid = 1'b0;
    case (state_q)
      ST_ACCUM: if (vs_rise) state_d = enough ? ST_DIV : ST_DONE;
      ST_DIV:   if (done_x && done_y) state_d = ST_DONE;
      ST_DONE: begin
        result_valid = 1'b1;
        state_d      = ST_ACCUM;
      end
      default:  state_d = ST_ACCUM;
    endcase
  end

  // Result registers update on entry to DONE so they are valid with the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      detected   <= 1'b0;
      centroid_x <= '0;
      centroid_y <= '0;
      overrun    <= 1'b0;
    end else begin
      if (accept && !enough)
        detected <= 1'b0;
      if (state_q == ST_DIV && done_x && done_y) begin
        detected   <= 1'b1;
        centroid_x <= quo_x[X_W-1:0];
        centroid_y <= quo_y[Y_W-1:0];
      end
      if (vs_rise && state_q != ST_ACCUM)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_skin_centroid.sv
// Bench for skin_centroid: frame generator, frame-level reference model
// and a per-cycle compare process with a few literal result checks.
module tb_skin_centroid;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        de = 1'b0, h_sync = 1'b0, v_sync = 1'b0;
  logic [7:0]  mask = 8'h00;
  int unsigned cur_x = 0, cur_y = 0;

  logic        de_out, h_sync_out, v_sync_out;
  logic [7:0]  pix_out;
  logic [10:0] centroid_x;
  logic [9:0]  centroid_y;
  logic        detected, result_valid, overrun;

  skin_centroid #(.H_RES(1280), .V_RES(720), .MIN_COUNT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .de           (de),
    .h_sync       (h_sync),
    .v_sync       (v_sync),
    .mask         (mask),
    .de_out       (de_out),
    .h_sync_out   (h_sync_out),
    .v_sync_out   (v_sync_out),
    .pix_out      (pix_out),
    .centroid_x   (centroid_x),
    .centroid_y   (centroid_y),
    .detected     (detected),
    .result_valid (result_valid),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          cyc = 0;
  logic        m_de_d = 0, m_hs_d = 0, m_vs_d = 0;
  logic [7:0]  m_pix_d = 0;
  int unsigned m_det = 0, m_cx = 0, m_cy = 0, m_ovr = 0;
  bit          m_pend = 0, m_vs_prev = 0;
  int          m_due = 0, acc_rise = 0;
  int unsigned p_det = 0, p_cx = 0, p_cy = 0;
  longint unsigned m_sx = 0, m_sy = 0;
  int unsigned m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_de_d = 0; m_hs_d = 0; m_vs_d = 0; m_pix_d = 0;
      m_det = 0; m_cx = 0; m_cy = 0; m_ovr = 0;
      m_pend = 0; m_vs_prev = 0;
      m_sx = 0; m_sy = 0; m_cnt = 0;
    end else begin
      cyc++;
      m_de_d = de; m_hs_d = h_sync; m_vs_d = v_sync;
      m_pix_d = mask;
`ifdef SKIN_CENTROID_MARK_EN
      if (de && m_det != 0 && (cur_x == m_cx || cur_y == m_cy)) m_pix_d = 8'h80;
`endif
      // a frame is in flight until one cycle past its result strobe
      if (m_pend && cyc > m_due + 1) m_pend = 0;
      if (de && !v_sync && mask != 8'h00) begin
        m_sx += cur_x; m_sy += cur_y; m_cnt++;
      end
      if (v_sync && !m_vs_prev) begin
        if (m_pend) m_ovr = 1;
        else begin
          acc_rise = cyc;
          m_pend = 1;
          if (m_cnt >= 16) begin
            m_due = cyc + 33; p_det = 1;
            p_cx = int'(m_sx / m_cnt); p_cy = int'(m_sy / m_cnt);
          end else begin
            m_due = cyc; p_det = 0;
          end
        end
        m_sx = 0; m_sy = 0; m_cnt = 0;
      end
      if (m_pend && cyc == m_due) begin
        m_det = p_det;
        if (p_det != 0) begin m_cx = p_cx; m_cy = p_cy; end
      end
      m_vs_prev = v_sync;
    end
  end

  // ---------------- compare ----------------
  int n_cmp = 0, n_err = 0;
  int res_n = 0, res_det = 0, res_cx = 0, res_cy = 0, res_lat = 0;
  int lit_req = 0, lit_done = 0;
  int exp_n, exp_det, exp_cx, exp_cy, exp_lat, exp_ovr;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    chk("de_out", longint'(de_out), longint'(m_de_d));
    chk("h_sync_out", longint'(h_sync_out), longint'(m_hs_d));
    chk("v_sync_out", longint'(v_sync_out), longint'(m_vs_d));
    chk("pix_out", longint'(pix_out), longint'(m_pix_d));
    chk("result_valid", longint'(result_valid), longint'(m_pend && cyc == m_due));
    chk("detected", longint'(detected), longint'(m_det));
    chk("centroid_x", longint'(centroid_x), longint'(m_cx));
    chk("centroid_y", longint'(centroid_y), longint'(m_cy));
    chk("overrun", longint'(overrun), longint'(m_ovr));
    if (rst_n && result_valid) begin
      res_n++;
      res_det = int'(detected);
      res_cx  = int'(centroid_x);
      res_cy  = int'(centroid_y);
      res_lat = cyc - acc_rise + 1;
    end
    if (lit_req != lit_done) begin
      chk("lit_result_count", longint'(res_n), longint'(exp_n));
      chk("lit_detected", longint'(res_det), longint'(exp_det));
      chk("lit_centroid_x", longint'(res_cx), longint'(exp_cx));
      chk("lit_centroid_y", longint'(res_cy), longint'(exp_cy));
      chk("lit_latency", longint'(res_lat), longint'(exp_lat));
      chk("lit_overrun", longint'(overrun), longint'(exp_ovr));
      lit_done = lit_req;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc1(input logic d, input logic hs, input logic vs,
                      input logic [7:0] m, input int unsigned px, input int unsigned py);
    de = d; h_sync = hs; v_sync = vs; mask = m; cur_x = px; cur_y = py;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc1(1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
  endtask

  task automatic vsync_pulse();
    repeat (3) cyc1(1'b0, 1'b0, 1'b1, 8'h00, 0, 0);
  endtask

  function automatic logic [7:0] skin_px(input int mode, input int unsigned x, input int unsigned y);
    case (mode)
      0:       return ($urandom_range(0, 3) == 0) ? 8'hFF : 8'h00;
      1:       return (x >= 100 && x <= 103 && y >= 50 && y <= 53) ? 8'hFF : 8'h00;
      2:       return 8'hFF;
      3:       return (y == 0 && x < 10) ? 8'hFF : 8'h00;
      default: return (x >= 1270) ? 8'hFF : 8'h00;
    endcase
  endfunction

  task automatic lines(input int unsigned w, input int unsigned nl, input int mode);
    for (int unsigned l = 0; l < nl; l++) begin
      for (int unsigned p = 0; p < w; p++)
        cyc1(1'b1, 1'b0, 1'b0, skin_px(mode, p, l), p, l);
      cyc1(1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
      cyc1(1'b0, 1'b1, 1'b0, 8'h00, 0, 0);
      cyc1(1'b0, 1'b1, 1'b0, 8'h00, 0, 0);
      cyc1(1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
    end
  endtask

  task automatic lit(input int n, input int det, input int cx, input int cy,
                     input int lat, input int ovr);
    exp_n = n; exp_det = det; exp_cx = cx; exp_cy = cy; exp_lat = lat; exp_ovr = ovr;
    lit_req++;
    for (int i = 0; i < 4 && lit_done != lit_req; i++) @(negedge clk);
    if (lit_done != lit_req) begin
      $display("FAIL lit_handshake: got %0d expected %0d", lit_done, lit_req);
      $fatal(1);
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);
    lit(0, 0, 0, 0, 0, 0);

    // empty first frame: below threshold, immediate result
    vsync_pulse(); idle(40);
    lit(1, 0, 0, 0, 1, 0);

    // 4x4 block at x 100..103, y 50..53
    lines(110, 56, 1); vsync_pulse(); idle(40);
    lit(2, 1, 101, 51, 34, 0);

    // 10 skin pixels: not detected, centroid held
    lines(20, 2, 3); vsync_pulse(); idle(40);
    lit(3, 0, 101, 51, 1, 0);

    // right edge of a full-width line
    lines(1280, 2, 4); vsync_pulse(); idle(40);
    lit(4, 1, 1274, 0, 34, 0);

    // all-skin frame
    lines(40, 20, 2); vsync_pulse(); idle(40);
    lit(5, 1, 19, 9, 34, 0);

    // random frames, model-checked only
    for (int f = 0; f < 4; f++) begin
      lines($urandom_range(16, 80), $urandom_range(4, 30), 0);
      vsync_pulse(); idle(40);
    end

    // second v_sync 10 cycles after the first, during division
    lines(40, 20, 2); vsync_pulse(); idle(7); vsync_pulse(); idle(40);
    lit(10, 1, 19, 9, 34, 1);
    lines(110, 56, 1); vsync_pulse(); idle(40);
    lit(11, 1, 101, 51, 34, 1);

    // reset in the middle of a division
    lines(40, 20, 2); vsync_pulse(); idle(11);
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);
    lit(11, 1, 101, 51, 34, 0);
    vsync_pulse(); idle(40);
    lit(12, 0, 0, 0, 1, 0);
    lines(110, 56, 1); vsync_pulse(); idle(40);
    lit(13, 1, 101, 51, 34, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
